// File: rtl/sorted_stream_out.sv
// Captures a sorted N-word vector from the parallel sorter and replays it one word
// per valid/ready handshake, ascending or descending, with index and last flags.
module sorted_stream_out #(
  parameter int N = 6,
  parameter int WIDTH = 8,
  localparam int IW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sort_done,
  input  logic [WIDTH-1:0] sort_data [N],
  input  logic             descending,
  input  logic             clr_overrun,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [IW-1:0]    m_index,
  output logic             m_last,
  output logic             busy,
  output logic             overrun
);

  // state  | meaning
  // IDLE   | waiting for a sort_done rising edge
  // STREAM | presenting data_q words; count selects the current beat
  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_q [N];
  logic             dir;
  logic [IW-1:0]    count, count_nxt, rd_idx;
  logic             sort_done_d;
  logic             cap_ev, capture, xfer, last, ovr_set;

  assign cap_ev = sort_done & ~sort_done_d;
  assign last   = (count == IW'(N - 1));
  assign xfer   = (state == STREAM) & m_ready;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    capture   = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (cap_ev) begin
          capture   = 1'b1;
          count_nxt = '0;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (xfer && last) begin
          // A new vector landing on the final beat is chained with no idle gap.
          count_nxt = '0;
          if (cap_ev) capture = 1'b1;
          else        state_nxt = IDLE;
        end else begin
          if (xfer)   count_nxt = count + IW'(1);
          if (cap_ev) ovr_set = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      dir         <= 1'b0;
      sort_done_d <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < N; i++) data_q[i] <= '0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      sort_done_d <= sort_done;
      overrun     <= ovr_set | (overrun & ~clr_overrun);
      if (capture) begin
        dir <= descending;
        for (int i = 0; i < N; i++) data_q[i] <= sort_data[i];
      end
    end
  end

  assign rd_idx  = dir ? (IW'(N - 1) - count) : count;
  assign m_valid = (state == STREAM);
  assign busy    = (state == STREAM);
  assign m_data  = m_valid ? data_q[rd_idx] : '0;
  assign m_index = m_valid ? count : '0;
  assign m_last  = m_valid & last;

endmodule

// File: tb/tb_sorted_stream_out.sv
// Scoreboard bench for sorted_stream_out: stimulus pushes expected beats, a negedge
// monitor pops and compares on each handshake and checks stability under backpressure.
module tb_sorted_stream_out;

  localparam int N = 6;
  localparam int WIDTH = 8;
  localparam int IW = $clog2(N);

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [IW-1:0]    i;
    logic             l;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             sort_done;
  logic [WIDTH-1:0] sort_data [N];
  logic             descending;
  logic             clr_overrun;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [IW-1:0]    m_index;
  logic             m_last;
  logic             busy;
  logic             overrun;

  int tests = 0;
  int fails = 0;
  beat_t sb [$];

  logic [WIDTH-1:0] vec_a [N];
  logic [WIDTH-1:0] vec_b [N];

  sorted_stream_out #(.N(N), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .sort_done(sort_done), .sort_data(sort_data),
    .descending(descending), .clr_overrun(clr_overrun), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .m_last(m_last),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_vec(input logic [WIDTH-1:0] v [N], input bit desc);
    beat_t b;
    for (int k = 0; k < N; k++) begin
      b.d = desc ? v[N-1-k] : v[k];
      b.i = IW'(k);
      b.l = (k == N - 1);
      sb.push_back(b);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  // Monitor: handshake scoreboard plus hold-stability while m_ready is low.
  logic             hold_pend = 1'b0;
  logic [WIDTH-1:0] hold_data;
  logic [IW-1:0]    hold_index;
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", {31'd0, m_valid}, 32'd1);
        check("hold_data", {24'd0, m_data}, {24'd0, hold_data});
        check("hold_index", {29'd0, m_index}, {29'd0, hold_index});
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("extra_beat", {24'd0, m_data}, 32'hFFFF_FFFF);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("beat_data", {24'd0, m_data}, {24'd0, e.d});
          check("beat_index", {29'd0, m_index}, {29'd0, e.i});
          check("beat_last", {31'd0, m_last}, {31'd0, e.l});
        end
      end
      hold_pend  = m_valid && !m_ready;
      hold_data  = m_data;
      hold_index = m_index;
    end
  end

  initial begin
    vec_a = '{8'd3, 8'd7, 8'd9, 8'd12, 8'd40, 8'd200};
    vec_b = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd255};
    rst = 1'b1;
    sort_done = 1'b0;
    sort_data = vec_a;
    descending = 1'b0;
    clr_overrun = 1'b0;
    m_ready = 1'b0;
    #3;
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {24'd0, m_data}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Basic ascending
    @(posedge clk); #1;
    push_vec(vec_a, 1'b0);
    sort_data = vec_a; descending = 1'b0; m_ready = 1'b1; sort_done = 1'b1;
    @(negedge clk);
    check("asc_valid_before_edge", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1 sort_done = 1'b0;
    @(negedge clk);
    check("asc_valid_after_edge", {31'd0, m_valid}, 32'd1);
    check("asc_busy", {31'd0, busy}, 32'd1);
    wait_idle("asc");
    check("asc_valid_low", {31'd0, m_valid}, 32'd0);
    check("asc_last_low", {31'd0, m_last}, 32'd0);
    check("asc_sb_empty", sb.size(), 32'd0);

    // Descending with backpressure pattern 1,0,0
    @(posedge clk); #1;
    push_vec(vec_a, 1'b1);
    descending = 1'b1; sort_done = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1 sort_done = 1'b0; descending = 1'b0;
    begin
      int i = 0;
      do begin
        m_ready = (i % 3 == 0);
        @(posedge clk); #1;
        i++;
      end while (busy && i < 100);
    end
    m_ready = 1'b1;
    check("desc_done", {31'd0, busy}, 32'd0);
    check("desc_sb_empty", sb.size(), 32'd0);

    // Held sort_done, then dropped second vector sets overrun
    @(posedge clk); #1;
    push_vec(vec_a, 1'b0);
    sort_data = vec_a; sort_done = 1'b1;
    repeat (3) @(posedge clk);
    #1 sort_done = 1'b0;
    @(posedge clk); #1 sort_done = 1'b1; sort_data = vec_b;
    @(posedge clk); #1 sort_done = 1'b0;
    @(negedge clk);
    check("held_overrun_set", {31'd0, overrun}, 32'd1);
    wait_idle("held");
    check("held_sb_empty", sb.size(), 32'd0);
    @(posedge clk); #1;
    check("held_overrun_sticky", {31'd0, overrun}, 32'd1);
    clr_overrun = 1'b1;
    @(posedge clk); #1 clr_overrun = 1'b0;
    check("held_overrun_cleared", {31'd0, overrun}, 32'd0);

    // Back-to-back: B edge coincides with A's last handshake
    @(posedge clk); #1;
    push_vec(vec_a, 1'b0);
    push_vec(vec_b, 1'b1);
    sort_data = vec_a; descending = 1'b0; sort_done = 1'b1;
    @(posedge clk); #1 sort_done = 1'b0;
    repeat (5) @(posedge clk);
    #1 sort_done = 1'b1; sort_data = vec_b; descending = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b2b_valid", {31'd0, m_valid}, 32'd1);
    check("b2b_index0", {29'd0, m_index}, 32'd0);
    check("b2b_data0", {24'd0, m_data}, 32'd255);
    sort_done = 1'b0; descending = 1'b0;
    wait_idle("b2b");
    check("b2b_sb_empty", sb.size(), 32'd0);
    check("b2b_overrun", {31'd0, overrun}, 32'd0);

    // Clear and set in the same cycle: set wins
    @(posedge clk); #1;
    push_vec(vec_a, 1'b0);
    sort_data = vec_a; sort_done = 1'b1; m_ready = 1'b0;
    @(posedge clk); #1 sort_done = 1'b0;
    @(posedge clk); #1 sort_done = 1'b1; clr_overrun = 1'b1;
    @(posedge clk); #1 sort_done = 1'b0; clr_overrun = 1'b0;
    check("clrset_overrun", {31'd0, overrun}, 32'd1);
    check("clrset_index_held", {29'd0, m_index}, 32'd0);
    m_ready = 1'b1;
    wait_idle("clrset");
    check("clrset_sb_empty", sb.size(), 32'd0);
    @(posedge clk); #1 clr_overrun = 1'b1;
    @(posedge clk); #1 clr_overrun = 1'b0;
    check("clrset_cleared", {31'd0, overrun}, 32'd0);

    // Reset mid-stream, then restart from a sort_done already high
    @(posedge clk); #1;
    push_vec(vec_a, 1'b0);
    sort_data = vec_a; sort_done = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1 sort_done = 1'b0;
    @(posedge clk); #1 sort_done = 1'b1;
    @(posedge clk); #1 sort_done = 1'b0;
    @(negedge clk);
    check("rstmid_overrun_pre", {31'd0, overrun}, 32'd1);
    @(posedge clk); #3;
    rst = 1'b1; sort_data = vec_b; sort_done = 1'b1;
    #1;
    check("rstmid_valid", {31'd0, m_valid}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_last", {31'd0, m_last}, 32'd0);
    check("rstmid_overrun", {31'd0, overrun}, 32'd0);
    sb.delete();
    push_vec(vec_b, 1'b0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_restart_valid", {31'd0, m_valid}, 32'd1);
    check("rstmid_restart_index", {29'd0, m_index}, 32'd0);
    sort_done = 1'b0;
    wait_idle("rstmid");
    check("rstmid_sb_empty", sb.size(), 32'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sorted_stream_out.md
Name: sorted_stream_out

Overview:
- Downstream stage of the parallel sort FSM.
- Captures the N-word sorted vector when the sorter signals completion.
- Emits the words one per handshake on a valid/ready stream, in ascending or descending order, with index and last flags.
- Lets the sorter's parallel result feed narrow consumers (UART/FIFO/display) without the sorter waiting on them.

Parameters:
- N, 6, number of words per sorted vector; must match the sorter; N >= 2.
- WIDTH, 8, bits per word.
- IW, $clog2(N), width of the index output; derived, not overridden.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sort_done  input  1  completion flag from sorter; may be held high one or more cycles.
- sort_data  input  WIDTH x N (unpacked array [N])  sorted vector, ascending, index 0 = smallest; valid while sort_done high.
- descending  input  1  order select, sampled only at capture.
- clr_overrun  input  1  synchronous clear of the overrun flag.
- m_valid  output  1  stream word valid.
- m_ready  input  1  consumer ready.
- m_data  output  WIDTH  current stream word.
- m_index  output  IW  position of m_data within the emitted sequence, 0..N-1.
- m_last  output  1  high with the final word of a vector.
- busy  output  1  high from capture until the last handshake completes.
- overrun  output  1  sticky: a new vector arrived while streaming and was dropped.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs go to 0, the state goes to IDLE, and the capture buffer, index/count and the sort_done delay register clear to 0.
- Edge detect: cap_ev = sort_done & ~sort_done_d. sort_done_d is registered and resets to 0, so sort_done already high at reset release counts as an edge on the first clock.
- States are IDLE and STREAM only.
- IDLE, on cap_ev:
  - Copy all N sort_data words into the buffer.
  - Latch descending into dir.
  - Set count=0.
  - Go to STREAM.
  - Latency: m_valid rises the cycle after the edge is seen.
- STREAM outputs:
  - m_valid=1, busy=1.
  - m_data = buf[count] if dir=0, else buf[N-1-count].
  - m_index = count.
  - m_last = (count==N-1).
  - All are registered or decoded from registers; no combinational path from inputs to outputs.
- Handshake:
  - A transfer occurs on a cycle with m_valid & m_ready.
  - While m_ready=0, m_data/m_index/m_last hold stable and m_valid stays high; valid is never withdrawn.
  - m_valid does not depend on m_ready.
- Transfer with count<N-1: count+1, stay in STREAM. Back-to-back transfers sustain one word per cycle.
- Transfer with count==N-1 (last):
  - Without cap_ev in the same cycle: go to IDLE; m_valid, busy and m_last drop the next cycle.
  - With cap_ev in the same cycle: capture the new vector, count=0, stay in STREAM. No gap cycle, no overrun.
- cap_ev in STREAM on any other cycle: the vector is dropped, the buffer is untouched, and overrun is set to 1.
- Overrun flag:
  - Stays set until clr_overrun=1.
  - If set and clear occur in the same cycle, set wins.
- Buffer: written only on accepted captures; sort_data is ignored at all other times.
- Reset mid-stream: immediate return to IDLE with all outputs 0. The partial vector is lost and no m_last is emitted.
- Order: no comparison is performed; order correctness relies on the sorter. Descending is pure index reversal, so equal values keep reversed positions.

Test Plan:
- Basic ascending (N=6, WIDTH=8):
  - Stimulus: sort_data={3,7,9,12,40,200}, descending=0, one-cycle sort_done, m_ready=1.
  - Required: m_valid rises the next cycle; 6 consecutive beats carry 3,7,9,12,40,200 with m_index 0..5; m_last only on 200; busy low the cycle after.
- Descending with backpressure:
  - Stimulus: same data, descending=1, m_ready toggled 1,0,0,1,...
  - Required: sequence 200,40,12,9,7,3; m_data/m_index stable across every ready-low cycle; exactly 6 transfers.
- Held done and overrun:
  - Stimulus: sort_done held high 3 cycles, then a second pulse with {0,0,1,1,2,255} during beat 2.
  - Required: only one capture from the held level; the original data stream completes; overrun=1 until clr_overrun pulses, then 0.
- Back-to-back vectors:
  - Stimulus: new sort_done edge coincides with the last handshake of vector A.
  - Required: vector B's first beat appears the next cycle with m_index=0; no idle gap; overrun stays 0.
- Simultaneous clear and set:
  - Stimulus: clr_overrun=1 on the same cycle as a dropped capture.
  - Required: overrun reads 1 afterward.
- Reset mid-stream:
  - Stimulus: assert rst asynchronously at beat 3.
  - Required: m_valid, busy, m_last, overrun = 0 immediately. After release, a sort_done already high triggers a fresh capture streaming from index 0.
